// File: rtl/shift_register_mode.sv
// Multi-mode word shift register: right/left shift, parallel load, hold and
// synchronous clear, with a saturating fill counter and a registered serial
// output. The valid flag on the serial word marks displaced words that were
// real data rather than reset filler.
module shift_register_mode #(
  parameter int N  = 8,
  parameter int NB = 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_valid,
  input  logic [1:0]      i_mode,
  input  logic            i_clear,
  input  logic [NB-1:0]   i_data,
  input  logic [N*NB-1:0] i_load_data,
  output logic [N*NB-1:0] o_data,
  output logic [NB-1:0]   o_serial,
  output logic            o_serial_valid,
  output logic [CW-1:0]   o_count,
  output logic            o_full
);

  localparam logic [1:0] MODE_RIGHT = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  localparam logic [CW-1:0] COUNT_MAX = CW'(N);

  logic [N*NB-1:0] data_q, data_d;
  logic [NB-1:0]   serial_q, serial_d;
  logic            serial_valid_q, serial_valid_d;
  logic [CW-1:0]   count_q, count_d;

  logic [N*NB-1:0] shr_data;
  logic [N*NB-1:0] shl_data;
  logic            full;
  logic [CW-1:0]   count_inc;

  // Per-word shift networks; edge words take the incoming word. Built word by
  // word so that N=1 never needs an empty slice.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_word
      if (gi == N - 1) begin : g_right_top
        assign shr_data[gi*NB +: NB] = i_data;
      end else begin : g_right_mid
        assign shr_data[gi*NB +: NB] = data_q[(gi+1)*NB +: NB];
      end
      if (gi == 0) begin : g_left_bot
        assign shl_data[gi*NB +: NB] = i_data;
      end else begin : g_left_mid
        assign shl_data[gi*NB +: NB] = data_q[(gi-1)*NB +: NB];
      end
    end
  endgenerate

  assign full      = (count_q == COUNT_MAX);
  assign count_inc = full ? count_q : count_q + CW'(1);

  // Next-state selection: clear beats a qualified operation, idle holds.
  always_comb begin
    data_d         = data_q;
    serial_d       = serial_q;
    serial_valid_d = 1'b0;
    count_d        = count_q;
    if (i_clear) begin
      data_d   = '0;
      serial_d = '0;
      count_d  = '0;
    end else if (i_enable && i_valid) begin
      case (i_mode)
        MODE_RIGHT: begin
          data_d         = shr_data;
          serial_d       = data_q[NB-1:0];
          serial_valid_d = full;
          count_d        = count_inc;
        end
        MODE_LEFT: begin
          data_d         = shl_data;
          serial_d       = data_q[N*NB-1 -: NB];
          serial_valid_d = full;
          count_d        = count_inc;
        end
        MODE_LOAD: begin
          data_d  = i_load_data;
          count_d = COUNT_MAX;
        end
        default: begin
          // hold: nothing changes, serial_valid already low
        end
      endcase
    end
  end

  // State registers with asynchronous reset to the empty state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_q         <= '0;
      serial_q       <= '0;
      serial_valid_q <= 1'b0;
      count_q        <= '0;
    end else begin
      data_q         <= data_d;
      serial_q       <= serial_d;
      serial_valid_q <= serial_valid_d;
      count_q        <= count_d;
    end
  end

  assign o_data         = data_q;
  assign o_serial       = serial_q;
  assign o_serial_valid = serial_valid_q;
  assign o_count        = count_q;
  assign o_full         = full;

endmodule
